run_controller: RTL and testbench

- Sequences the pipelined datapath for the debug flow.
- Decodes single-byte run commands from the UART receive FIFO.
- Drives the pipeline-wide enable and synchronous clear (pipeEnable/pipeReset) in continuous or single-step mode.
- Counts executed cycles and hands off to the register/latch dump sequencer (dumpStart/dumpDone) after every step and at end of program.

---
 rtl/run_controller.sv | 187 ++++++++++++++++++
 tb/tb_run_controller.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/run_controller.sv
`default_nettype none
// ============================================================================
// Module   : run_controller
// Brief    : Debug-flow run sequencer. Decodes single-byte UART commands,
//            drives the pipeline enable/clear in continuous or single-step
//            mode, counts enabled cycles and hands off to the dump sequencer.
// Options  : RUN_CTRL_WATCHDOG_EN - cycle-limit watchdog in continuous mode
// Revision : 1.0 - initial release
// ============================================================================
module run_controller #(
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 1000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       cmdData,
  input  logic             cmdAvailable,
  output logic             cmdRead,
  input  logic             endOfProgram,
  input  logic             dumpDone,
  output logic             dumpStart,
  output logic             pipeEnable,
  output logic             pipeReset,
  output logic [CNT_W-1:0] cycleCount,
  output logic             ledIdle,
  output logic             ledCont,
  output logic             ledStep,
  output logic             ledSend,
  output logic             timeout
);

  localparam logic [7:0] C_CMD_CONT = 8'h63;
  localparam logic [7:0] C_CMD_STEP = 8'h73;
  localparam logic [7:0] C_CMD_NEXT = 8'h6E;
  localparam logic [7:0] C_CMD_RET  = 8'h72;

  // CLR_* hold the one-cycle pipeline clear; DUMP_S is the dumpStart cycle,
  // DUMP_W waits for dumpDone so a done pulse in the entry cycle is ignored.
  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_CLR_C     = 4'd1,
    S_CLR_S     = 4'd2,
    S_CONT      = 4'd3,
    S_STEP_WAIT = 4'd4,
    S_STEP      = 4'd5,
    S_DUMP_S    = 4'd6,
    S_DUMP_W    = 4'd7,
    S_DONE      = 4'd8
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cycleCount;
  logic             r_eopSeen;
  logic             w_setEop;
  logic             w_wdExpired;

`ifdef RUN_CTRL_WATCHDOG_EN
  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_CYCLES);
  logic r_timeout;
  logic w_setTimeout;
  assign w_wdExpired = (r_cycleCount >= C_MAX);
  assign timeout     = r_timeout;
`else
  logic [CNT_W-1:0] w_unused_max;
  assign w_unused_max = CNT_W'(MAX_CYCLES);
  assign w_wdExpired  = 1'b0;
  assign timeout      = 1'b0;
`endif

  assign cycleCount = r_cycleCount;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode and all strobes/indicators
  always_comb begin
    w_next     = r_state;
    cmdRead    = 1'b0;
    dumpStart  = 1'b0;
    pipeEnable = 1'b0;
    pipeReset  = 1'b0;
    ledIdle    = 1'b0;
    ledCont    = 1'b0;
    ledStep    = 1'b0;
    ledSend    = 1'b0;
    w_setEop   = 1'b0;
`ifdef RUN_CTRL_WATCHDOG_EN
    w_setTimeout = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        ledIdle = 1'b1;
        if (cmdAvailable) begin
          cmdRead = 1'b1;
          if (cmdData == C_CMD_CONT)      w_next = S_CLR_C;
          else if (cmdData == C_CMD_STEP) w_next = S_CLR_S;
        end
      end
      S_CLR_C: begin
        ledCont   = 1'b1;
        pipeReset = 1'b1;
        w_next    = S_CONT;
      end
      S_CLR_S: begin
        ledStep   = 1'b1;
        pipeReset = 1'b1;
        w_next    = S_STEP_WAIT;
      end
      S_CONT: begin
        ledCont = 1'b1;
        if (endOfProgram) begin
          w_setEop = 1'b1;
          w_next   = S_DUMP_S;
        end else if (w_wdExpired) begin
          w_setEop = 1'b1;
`ifdef RUN_CTRL_WATCHDOG_EN
          w_setTimeout = 1'b1;
`endif
          w_next   = S_DUMP_S;
        end else begin
          pipeEnable = 1'b1;
        end
      end
      S_STEP_WAIT: begin
        ledStep = 1'b1;
        if (cmdAvailable) begin
          cmdRead = 1'b1;
          if (cmdData == C_CMD_NEXT)     w_next = S_STEP;
          else if (cmdData == C_CMD_RET) w_next = S_IDLE;
        end
      end
      S_STEP: begin
        ledStep    = 1'b1;
        pipeEnable = 1'b1;
        w_next     = S_DUMP_S;
      end
      S_DUMP_S: begin
        ledSend   = 1'b1;
        dumpStart = 1'b1;
        w_setEop  = endOfProgram;
        w_next    = S_DUMP_W;
      end
      S_DUMP_W: begin
        ledSend  = 1'b1;
        w_setEop = endOfProgram;
        if (dumpDone) w_next = (r_eopSeen || endOfProgram) ? S_DONE : S_STEP_WAIT;
      end
      S_DONE: begin
        ledIdle = 1'b1;
        if (cmdAvailable) begin
          cmdRead = 1'b1;
          if (cmdData == C_CMD_RET) w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Enabled-cycle counter: cleared by pipeReset, saturating at all-ones
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                  r_cycleCount <= '0;
    else if (pipeReset)                          r_cycleCount <= '0;
    else if (pipeEnable && (r_cycleCount != '1)) r_cycleCount <= r_cycleCount + 1'b1;
  end

  // End-of-program memory, cleared whenever IDLE is (re)entered
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                 r_eopSeen <= 1'b0;
    else if (w_next == S_IDLE)  r_eopSeen <= 1'b0;
    else if (w_setEop)          r_eopSeen <= 1'b1;
  end

`ifdef RUN_CTRL_WATCHDOG_EN
  // Sticky watchdog flag, cleared on IDLE entry
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                r_timeout <= 1'b0;
    else if (w_next == S_IDLE) r_timeout <= 1'b0;
    else if (w_setTimeout)     r_timeout <= 1'b1;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_run_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_run_controller
// Brief    : Directed self-checking bench for run_controller. Inputs change
//            on the falling edge and outputs are checked 1 time unit later.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_run_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  cmdData = 8'h00;
  logic        cmdAvailable = 1'b0;
  logic        cmdRead;
  logic        endOfProgram = 1'b0;
  logic        dumpDone = 1'b0;
  logic        dumpStart;
  logic        pipeEnable;
  logic        pipeReset;
  logic [31:0] cycleCount;
  logic        ledIdle, ledCont, ledStep, ledSend;
  logic        timeout;

  int total = 0;
  int bad   = 0;

  // Edge-sampled event counters
  int n_en  = 0;
  int n_prs = 0;
  int n_ds  = 0;

  run_controller #(.CNT_W(32), .MAX_CYCLES(50)) dut (
    .clock(clock), .reset(reset),
    .cmdData(cmdData), .cmdAvailable(cmdAvailable), .cmdRead(cmdRead),
    .endOfProgram(endOfProgram), .dumpDone(dumpDone), .dumpStart(dumpStart),
    .pipeEnable(pipeEnable), .pipeReset(pipeReset), .cycleCount(cycleCount),
    .ledIdle(ledIdle), .ledCont(ledCont), .ledStep(ledStep), .ledSend(ledSend),
    .timeout(timeout)
  );

  always #5 clock = ~clock;

  // Count strobes exactly as the pipeline would see them
  always @(posedge clock) begin
    if (pipeEnable) n_en  <= n_en + 1;
    if (pipeReset)  n_prs <= n_prs + 1;
    if (dumpStart)  n_ds  <= n_ds + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  // Present one byte for one cycle; returns #1 after the following falling edge
  task automatic send(input logic [7:0] b, input string tag);
    cyc();
    cmdData = b;
    cmdAvailable = 1'b1;
    #1 chk({tag, "_cmdRead"}, {31'd0, cmdRead}, 32'd1);
    cyc();
    cmdAvailable = 1'b0;
    #1;
  endtask

  // Pulse dumpDone for one cycle; returns #1 after it has been taken
  task automatic pulse_done();
    cyc();
    dumpDone = 1'b1;
    cyc();
    dumpDone = 1'b0;
    #1;
  endtask

  int en0, prs0, ds0;

  initial begin
    // ---------------- reset state ----------------
    #12;
    chk("rst_ledIdle", {31'd0, ledIdle}, 32'd1);
    chk("rst_outs", {24'd0, cmdRead, dumpStart, pipeEnable, pipeReset, ledCont, ledStep, ledSend, timeout}, 32'd0);
    chk("rst_count", cycleCount, 32'd0);
    cyc();
    reset = 1'b1;
    cyc();

    // ---------------- continuous run, EOP after 20 enabled cycles ----------------
    en0 = n_en; prs0 = n_prs; ds0 = n_ds;
    send(8'h63, "cont");
    chk("cont_pipeReset", {31'd0, pipeReset}, 32'd1);
    chk("cont_noEnDuringClr", {31'd0, pipeEnable}, 32'd0);
    cyc();
    #1 chk("cont_enable", {31'd0, pipeEnable}, 32'd1);
    chk("cont_ledCont", {31'd0, ledCont}, 32'd1);
    chk("cont_noRead", {31'd0, cmdRead}, 32'd0);
    for (int i = 0; i < 19; i++) cyc();
    cyc();
    endOfProgram = 1'b1;
    #1 chk("cont_count20", cycleCount, 32'd20);
    chk("cont_freeze", {31'd0, pipeEnable}, 32'd0);
    cyc();
    endOfProgram = 1'b0;
    #1 chk("cont_dumpStart", {31'd0, dumpStart}, 32'd1);
    chk("cont_ledSend", {31'd0, ledSend}, 32'd1);
    cyc();
    #1 chk("cont_dumpStartOnce", {31'd0, dumpStart}, 32'd0);
    cyc(); cyc();
    pulse_done();
    chk("cont_doneLed", {28'd0, ledIdle, ledCont, ledStep, ledSend}, 32'b1000);
    chk("cont_enCycles", n_en - en0, 32'd20);
    chk("cont_prsPulses", n_prs - prs0, 32'd1);
    chk("cont_dsPulses", n_ds - ds0, 32'd1);
    chk("cont_countHeld", cycleCount, 32'd20);
    chk("cont_noTimeout", {31'd0, timeout}, 32'd0);

    // ---------------- junk in DONE, return, junk in IDLE ----------------
    send(8'h41, "doneJunk");
    chk("doneJunk_ledIdle", {31'd0, ledIdle}, 32'd1);
    send(8'h72, "ret");
    chk("ret_ledIdle", {31'd0, ledIdle}, 32'd1);
    send(8'h41, "idleJunk");
    chk("idleJunk_noClr", {31'd0, pipeReset}, 32'd0);
    chk("idleJunk_count", cycleCount, 32'd20);

    // ---------------- step mode: three steps ----------------
    en0 = n_en; ds0 = n_ds;
    send(8'h73, "step");
    chk("step_pipeReset", {31'd0, pipeReset}, 32'd1);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      #1 chk("step_waitNoEn", {31'd0, pipeEnable}, 32'd0);
      send(8'h6E, "next");
      chk("step_enPulse", {31'd0, pipeEnable}, 32'd1);
      cyc();
      if (k == 1) dumpDone = 1'b1;   // must be ignored in the dumpStart cycle
      #1 chk("step_dumpStart", {31'd0, dumpStart}, 32'd1);
      chk("step_dumpNoEn", {31'd0, pipeEnable}, 32'd0);
      cyc();
      dumpDone = 1'b0;
      cyc(); cyc(); cyc();
      #1 chk("step_stillDump", {31'd0, ledSend}, 32'd1);
      pulse_done();
      chk("step_backWait", {28'd0, ledIdle, ledCont, ledStep, ledSend}, 32'b0010);
      chk("step_count", cycleCount, k);
    end
    chk("step_enCycles", n_en - en0, 32'd3);
    chk("step_dsPulses", n_ds - ds0, 32'd3);

    // ---------------- EOP during a step dump ----------------
    send(8'h6E, "eopNext");
    cyc();
    cyc();
    endOfProgram = 1'b1;
    #1 chk("eop_inDump", {31'd0, ledSend}, 32'd1);
    cyc();
    endOfProgram = 1'b0;
    pulse_done();
    chk("eop_done", {28'd0, ledIdle, ledCont, ledStep, ledSend}, 32'b1000);
    chk("eop_count", cycleCount, 32'd4);
    en0 = n_en;
    send(8'h6E, "doneNext");
    cyc();
    #1 chk("doneNext_noEn", n_en - en0, 32'd0);
    chk("doneNext_ledIdle", {31'd0, ledIdle}, 32'd1);
    chk("doneNext_count", cycleCount, 32'd4);

    // ---------------- restart clears eopSeen; async reset mid-dump ----------------
    send(8'h72, "ret2");
    send(8'h73, "step2");
    send(8'h6E, "next2");
    cyc();
    #1 chk("clr_dumpStart", {31'd0, dumpStart}, 32'd1);
    pulse_done();
    chk("clr_eopCleared", {31'd0, ledStep}, 32'd1);
    send(8'h6E, "next3");
    cyc();
    #1 chk("ar_dumpStart", {31'd0, dumpStart}, 32'd1);
    cyc();
    #2 reset = 1'b0;
    #1 chk("ar_ledIdle", {31'd0, ledIdle}, 32'd1);
    chk("ar_outs", {24'd0, cmdRead, dumpStart, pipeEnable, pipeReset, ledCont, ledStep, ledSend, timeout}, 32'd0);
    chk("ar_count", cycleCount, 32'd0);
    cyc();
    reset = 1'b1;
    pulse_done();
    chk("ar_lateDone", {28'd0, ledIdle, ledCont, ledStep, ledSend}, 32'b1000);
    cyc();
    #1 chk("ar_quiet", {29'd0, dumpStart, pipeEnable, pipeReset}, 32'd0);

`ifdef RUN_CTRL_WATCHDOG_EN
    // ---------------- watchdog at 50 enabled cycles ----------------
    send(8'h63, "wd");
    begin : wd_wait
      int guard;
      guard = 0;
      while (cycleCount != 32'd50 && guard < 200) begin
        cyc();
        #1 guard++;
      end
      chk("wd_reached", {31'd0, guard < 200}, 32'd1);
    end
    chk("wd_enLow", {31'd0, pipeEnable}, 32'd0);
    cyc();
    #1 chk("wd_timeout", {31'd0, timeout}, 32'd1);
    chk("wd_dumpStart", {31'd0, dumpStart}, 32'd1);
    chk("wd_countStop", cycleCount, 32'd50);
    pulse_done();
    chk("wd_done", {28'd0, ledIdle, ledCont, ledStep, ledSend}, 32'b1000);
    chk("wd_sticky", {31'd0, timeout}, 32'd1);
    send(8'h72, "wdRet");
    chk("wd_cleared", {31'd0, timeout}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
